// File: rtl/mem_access_stage.sv
// mem_access_stage: memory (ME) pipeline stage.
// Issues one data-memory transaction per load/store over a req/ack handshake,
// stalls the pipeline while the access is outstanding, aligns byte accesses
// and registers the writeback result into the ME pipeline register.
module mem_access_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        AnyStall,
    input  logic [31:0] Result_EX,
    input  logic [31:0] WrDat_EX,
    input  logic [4:0]  WriteReg_EX,
    input  logic        RegWrite_EX,
    input  logic        MemToReg_EX,
    input  logic        MemWrite_EX,
    input  logic        LoadB_EX,
    input  logic        StoreB_EX,
    input  logic        InstrVal_EX,
    output logic        DmReq,
    output logic        DmWe,
    output logic [31:0] DmAddr,
    output logic [31:0] DmWrDat,
    output logic [3:0]  DmBe,
    input  logic        DmAck,
    input  logic [31:0] DmRdDat,
    output logic        MemStall_ME,
    output logic [31:0] ResultRdDat_ME,
    output logic [4:0]  WriteReg_ME,
    output logic        RegWrite_ME,
    output logic        InstrVal_ME,
    output logic        AdrErr_ME
);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state_r;
    state_t      stateNext_s;
    logic        done_r;
    logic        doneNext_s;
    logic        discard_r;
    logic        discardNext_s;

    logic        isMem_s;
    logic        memOp_s;
    logic        wordAcc_s;
    logic        misalign_s;
    logic        alignedOp_s;
    logic        validNonMem_s;
    logic        nonMemCap_s;
    logic        ack_s;
    logic [31:0] loadRes_s;

    logic        meVal_s;
    logic        meRw_s;
    logic [4:0]  meWr_s;
    logic [31:0] meRes_s;
    logic        adrErr_s;

    // One-hot byte-lane enable for a byte store; lane 0 is bits 7:0.
    function automatic logic [3:0] laneEnable(input logic [1:0] lane);
        logic [3:0] be;
        case (lane)
            2'd0:    be = 4'b0001;
            2'd1:    be = 4'b0010;
            2'd2:    be = 4'b0100;
            2'd3:    be = 4'b1000;
            default: be = 4'b0001;
        endcase
        return be;
    endfunction

    // Select one byte of the read word and sign-extend it to 32 bits.
    function automatic logic [31:0] loadByte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return {{24{b[7]}}, b};
    endfunction

    // Classify the instruction currently held in the EX register.
    always_comb begin
        isMem_s       = InstrVal_EX & (MemToReg_EX | MemWrite_EX);
        memOp_s       = isMem_s & ~done_r;
        wordAcc_s     = ~LoadB_EX & ~StoreB_EX;
        misalign_s    = memOp_s & wordAcc_s & (Result_EX[1:0] != 2'b00);
        alignedOp_s   = memOp_s & ~misalign_s;
        validNonMem_s = InstrVal_EX & ~(MemToReg_EX | MemWrite_EX) & ~done_r;
        nonMemCap_s   = ~isMem_s & ~done_r;
    end

    // Data-memory port; everything is derived from the held EX register so it stays stable in WAIT.
    always_comb begin
        if (state_r == WAIT) begin
            DmReq = 1'b1;
        end else begin
            DmReq = alignedOp_s;
        end
        ack_s       = DmReq & DmAck;
        MemStall_ME = DmReq & ~DmAck;
        DmWe        = DmReq & MemWrite_EX;
        DmAddr      = {Result_EX[31:2], 2'b00};
        if (StoreB_EX & MemWrite_EX) begin
            DmBe    = laneEnable(Result_EX[1:0]);
            DmWrDat = {4{WrDat_EX[7:0]}};
        end else begin
            DmBe    = 4'hF;
            DmWrDat = WrDat_EX;
        end
        if (LoadB_EX) begin
            loadRes_s = loadByte(DmRdDat, Result_EX[1:0]);
        end else begin
            loadRes_s = DmRdDat;
        end
    end

    // Next state of the handshake FSM; a flushed access still runs to DmAck but its data is discarded.
    always_comb begin
        case (state_r)
            IDLE: begin
                if (alignedOp_s & ~DmAck) begin
                    stateNext_s   = WAIT;
                    discardNext_s = flush;
                end else begin
                    stateNext_s   = IDLE;
                    discardNext_s = 1'b0;
                end
            end
            WAIT: begin
                if (DmAck) begin
                    stateNext_s   = IDLE;
                    discardNext_s = 1'b0;
                end else begin
                    stateNext_s   = WAIT;
                    discardNext_s = discard_r | flush;
                end
            end
            default: begin
                stateNext_s   = IDLE;
                discardNext_s = 1'b0;
            end
        endcase
    end

    // Done marks an instruction already handled while EX holds it, so it is never replayed.
    always_comb begin
        if (flush) begin
            doneNext_s = 1'b0;
        end else if (~AnyStall) begin
            doneNext_s = 1'b0;
        end else if (ack_s | misalign_s | validNonMem_s) begin
            doneNext_s = 1'b1;
        end else begin
            doneNext_s = done_r;
        end
    end

    // Next contents of the ME pipeline register; anything not captured becomes a bubble.
    always_comb begin
        meVal_s  = 1'b0;
        meRw_s   = 1'b0;
        meWr_s   = 5'd0;
        meRes_s  = 32'd0;
        adrErr_s = misalign_s & ~flush;
        if (flush | MemStall_ME | done_r) begin
            meVal_s = 1'b0;
        end else if (ack_s) begin
            if (discard_r) begin
                meVal_s = 1'b0;
            end else begin
                meVal_s = 1'b1;
                meRw_s  = RegWrite_EX & ~MemWrite_EX;
                meWr_s  = WriteReg_EX;
                if (MemToReg_EX) begin
                    meRes_s = loadRes_s;
                end else begin
                    meRes_s = Result_EX;
                end
            end
        end else if (nonMemCap_s & InstrVal_EX) begin
            meVal_s = 1'b1;
            meRw_s  = RegWrite_EX;
            meWr_s  = WriteReg_EX;
            meRes_s = Result_EX;
        end else begin
            meVal_s = 1'b0;
        end
    end

    // FSM state and the done/discard flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            done_r    <= 1'b0;
            discard_r <= 1'b0;
        end else begin
            state_r   <= stateNext_s;
            done_r    <= doneNext_s;
            discard_r <= discardNext_s;
        end
    end

    // ME pipeline register feeding the register file and the bypass network.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrVal_ME    <= 1'b0;
            RegWrite_ME    <= 1'b0;
            WriteReg_ME    <= 5'd0;
            ResultRdDat_ME <= 32'd0;
            AdrErr_ME      <= 1'b0;
        end else begin
            InstrVal_ME    <= meVal_s;
            RegWrite_ME    <= meRw_s;
            WriteReg_ME    <= meWr_s;
            ResultRdDat_ME <= meRes_s;
            AdrErr_ME      <= adrErr_s;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: randomized instruction stream with a
// scoreboard for ME writebacks and one for data-memory transactions.
module tb_mem_access_stage;

    localparam int K_BUB = 0;
    localparam int K_NM  = 1;
    localparam int K_LW  = 2;
    localparam int K_LB  = 3;
    localparam int K_SW  = 4;
    localparam int K_SB  = 5;
    localparam int NRAND = 250;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic [4:0]  wr;
        bit          rw;
        int          lat;
        int          hold;
        bit          fl;
    } instr_t;

    typedef struct {
        int          id;
        bit          isErr;
        bit          isStore;
        logic [31:0] res;
        logic [4:0]  wr;
        bit          rw;
    } exp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [3:0]  be;
        int          lat;
    } memexp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        extStall;
    logic        AnyStall;
    logic [31:0] Result_EX, WrDat_EX;
    logic [4:0]  WriteReg_EX;
    logic        RegWrite_EX, MemToReg_EX, MemWrite_EX, LoadB_EX, StoreB_EX, InstrVal_EX;
    logic        DmReq, DmWe;
    logic [31:0] DmAddr, DmWrDat;
    logic [3:0]  DmBe;
    logic        DmAck;
    logic [31:0] DmRdDat;
    logic        MemStall_ME;
    logic [31:0] ResultRdDat_ME;
    logic [4:0]  WriteReg_ME;
    logic        RegWrite_ME, InstrVal_ME, AdrErr_ME;

    int checks = 0;
    int fails  = 0;

    instr_t  prog[$];
    exp_t    expQ[$];
    memexp_t memQ[$];
    bit      killed[0:1023];
    bit      emitted[0:1023];

    assign AnyStall = MemStall_ME | extStall;

    mem_access_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .AnyStall(AnyStall),
        .Result_EX(Result_EX), .WrDat_EX(WrDat_EX), .WriteReg_EX(WriteReg_EX),
        .RegWrite_EX(RegWrite_EX), .MemToReg_EX(MemToReg_EX), .MemWrite_EX(MemWrite_EX),
        .LoadB_EX(LoadB_EX), .StoreB_EX(StoreB_EX), .InstrVal_EX(InstrVal_EX),
        .DmReq(DmReq), .DmWe(DmWe), .DmAddr(DmAddr), .DmWrDat(DmWrDat), .DmBe(DmBe),
        .DmAck(DmAck), .DmRdDat(DmRdDat), .MemStall_ME(MemStall_ME),
        .ResultRdDat_ME(ResultRdDat_ME), .WriteReg_ME(WriteReg_ME),
        .RegWrite_ME(RegWrite_ME), .InstrVal_ME(InstrVal_ME), .AdrErr_ME(AdrErr_ME)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input int kind, input logic [31:0] addr, input logic [31:0] wdat,
                                  input logic [31:0] rdat, input logic [4:0] wr, input int lat,
                                  input int hold, input bit fl);
        instr_t x;
        x.kind = kind; x.addr = addr; x.wdat = wdat; x.rdat = rdat; x.wr = wr;
        x.rw = 1'b1; x.lat = lat; x.hold = hold; x.fl = fl;
        return x;
    endfunction

    function automatic instr_t randInstr();
        instr_t x;
        x.kind = int'($urandom_range(0, 5));
        x.addr = $urandom;
        if ((x.kind == K_LW || x.kind == K_SW) && $urandom_range(0, 3) != 0) x.addr[1:0] = 2'b00;
        x.wdat = $urandom;
        x.rdat = $urandom;
        x.wr   = 5'($urandom_range(0, 31));
        x.rw   = 1'($urandom_range(0, 1));
        x.lat  = int'($urandom_range(0, 3));
        x.hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        x.fl   = ($urandom_range(0, 7) == 0);
        return x;
    endfunction

    // Reference model: what each instruction must produce, from the stage's rules alone.
    task automatic issue(input instr_t x, input int id);
        exp_t        e;
        memexp_t     m;
        int          lane;
        logic [31:0] b;
        if (x.kind == K_BUB) return;
        lane      = int'(x.addr[1:0]);
        e.id      = id;
        e.isErr   = 1'b0;
        e.isStore = (x.kind == K_SW || x.kind == K_SB);
        e.wr      = x.wr;
        e.rw      = x.rw && !e.isStore;
        e.res     = x.addr;
        if ((x.kind == K_LW || x.kind == K_SW) && lane != 0) begin
            e.isErr = 1'b1;
            expQ.push_back(e);
            return;
        end
        if (x.kind != K_NM) begin
            m.we   = e.isStore;
            m.addr = x.addr - 32'(lane);
            m.be   = (x.kind == K_SB) ? 4'(1 << lane) : 4'hF;
            m.wdat = (x.kind == K_SB) ? (x.wdat & 32'hFF) * 32'h01010101 : x.wdat;
            m.lat  = x.lat;
            memQ.push_back(m);
        end
        if (x.kind == K_LW) e.res = x.rdat;
        if (x.kind == K_LB) begin
            b     = (x.rdat >> (8 * lane)) & 32'hFF;
            e.res = (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
        end
        expQ.push_back(e);
    endtask

    task automatic driveEx(input instr_t x);
        InstrVal_EX = (x.kind != K_BUB);
        Result_EX   = x.addr;
        WrDat_EX    = x.wdat;
        WriteReg_EX = x.wr;
        RegWrite_EX = x.rw;
        MemToReg_EX = (x.kind == K_LW || x.kind == K_LB) || (x.kind == K_BUB && x.addr[4]);
        MemWrite_EX = (x.kind == K_SW || x.kind == K_SB);
        LoadB_EX    = (x.kind == K_LB);
        StoreB_EX   = (x.kind == K_SB);
    endtask

    // Monitor: pops the writeback scoreboard whenever ME presents an instruction or an error.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (InstrVal_ME || AdrErr_ME) begin
                    while (expQ.size() > 0 && killed[expQ[0].id]) void'(expQ.pop_front());
                    if (expQ.size() == 0) begin
                        chk("unexpected_me_output", 32'(InstrVal_ME), 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        emitted[e.id] = 1'b1;
                        if (e.isErr) begin
                            chk("adrerr_pulse", 32'(AdrErr_ME), 32'd1);
                            chk("adrerr_instrval", {31'd0, InstrVal_ME}, 32'd0);
                            chk("adrerr_regwrite", {31'd0, RegWrite_ME}, 32'd0);
                        end else begin
                            chk("me_no_adrerr", {31'd0, AdrErr_ME}, 32'd0);
                            chk("me_instrval", {31'd0, InstrVal_ME}, 32'd1);
                            chk("me_writereg", {27'd0, WriteReg_ME}, {27'd0, e.wr});
                            chk("me_regwrite", {31'd0, RegWrite_ME}, {31'd0, e.rw});
                            if (!e.isStore) chk("me_result", ResultRdDat_ME, e.res);
                        end
                    end
                end else begin
                    chk("bubble_zero", ResultRdDat_ME | {26'd0, WriteReg_ME, RegWrite_ME}, 32'd0);
                end
            end
        end
    end

    // Driver: plays the EX register and the data memory, checking each memory transaction.
    initial begin : driver
        instr_t  cur;
        memexp_t burst;
        int      idx = 0, cyc = 0, curId = -1, w = 0, stallCnt = 0, cycles = 0, tail = 0;
        bit      prevStall = 1'b0, flushed = 1'b0, inBurst = 1'b0;

        prog.push_back(mk(K_LW, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5, 0, 0, 1'b0));
        prog.push_back(mk(K_SB, 32'h203, 32'h12345680, 32'h0, 5'd6, 3, 0, 1'b0));
        prog.push_back(mk(K_LB, 32'h41, 32'h0, 32'h0000F200, 5'd7, 0, 0, 1'b0));
        prog.push_back(mk(K_LW, 32'h102, 32'h0, 32'h11111111, 5'd8, 0, 0, 1'b0));
        prog.push_back(mk(K_LW, 32'h180, 32'h0, 32'hCAFEF00D, 5'd9, 0, 3, 1'b0));
        prog.push_back(mk(K_NM, 32'h00000ABC, 32'h0, 32'h0, 5'd10, 0, 0, 1'b0));
        prog.push_back(mk(K_SW, 32'h400, 32'hA5A5A5A5, 32'h0, 5'd11, 3, 1, 1'b1));
        for (int i = 0; i < NRAND; i++) prog.push_back(randInstr());
        cur = mk(K_BUB, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 1'b0);

        rst_n = 1'b0; flush = 1'b0; extStall = 1'b0; DmAck = 1'b0; DmRdDat = 32'h0;
        driveEx(cur);
        #3;
        chk("reset_dmreq", {31'd0, DmReq}, 32'd0);
        chk("reset_memstall", {31'd0, MemStall_ME}, 32'd0);
        chk("reset_me_regs", ResultRdDat_ME | {25'd0, WriteReg_ME, RegWrite_ME, InstrVal_ME}, 32'd0);
        chk("reset_adrerr", {31'd0, AdrErr_ME}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        while (cycles < 20000) begin
            @(negedge clk);
            #2;
            cycles++;
            if (!prevStall) begin
                if (idx < prog.size()) begin
                    cur = prog[idx]; curId = idx; issue(cur, idx); idx++;
                end else begin
                    cur = mk(K_BUB, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 1'b0); curId = -1;
                end
                cyc = 0; flushed = 1'b0;
                driveEx(cur);
            end else begin
                cyc++;
            end
            extStall = (curId >= 0) && (cyc < cur.hold);
            flush    = 1'b0;
            if (curId >= 0 && cur.fl && !flushed && !extStall) begin
                flush = 1'b1; flushed = 1'b1;
                if (!emitted[curId]) killed[curId] = 1'b1;
            end
            DmAck   = 1'b0;
            DmRdDat = cur.rdat;
            #1;
            if (DmReq) begin
                if (!inBurst) begin
                    if (memQ.size() == 0) begin
                        chk("spurious_dmreq", 32'(DmReq), 32'd0);
                    end else begin
                        burst = memQ.pop_front();
                        chk("dm_we", {31'd0, DmWe}, {31'd0, burst.we});
                        chk("dm_addr", DmAddr, burst.addr);
                        chk("dm_be", {28'd0, DmBe}, {28'd0, burst.be});
                        if (burst.we) chk("dm_wrdat", DmWrDat, burst.wdat);
                        inBurst = 1'b1; w = 0; stallCnt = 0;
                    end
                end else begin
                    chk("dm_stable", (DmAddr ^ burst.addr) | {27'd0, DmBe ^ burst.be, DmWe ^ burst.we},
                        32'd0);
                end
                if (inBurst && w == burst.lat) DmAck = 1'b1;
            end else begin
                if (inBurst) begin
                    chk("dmreq_dropped", {31'd0, DmReq}, 32'd1);
                    inBurst = 1'b0;
                end
                chk("idle_no_stall", {31'd0, MemStall_ME}, 32'd0);
                DmAck = ($urandom_range(0, 3) == 0);
            end
            #1;
            if (inBurst) begin
                stallCnt += int'(MemStall_ME);
                if (DmAck) begin
                    chk("stall_cycles", 32'(stallCnt), 32'(burst.lat));
                    inBurst = 1'b0;
                end else begin
                    w++;
                end
            end
            prevStall = MemStall_ME | extStall;
            if (idx >= prog.size() && !prevStall && !inBurst && curId < 0) tail++;
            if (tail > 4) break;
        end
        if (cycles >= 20000) chk("timeout", 32'(cycles), 32'd0);

        // Asynchronous reset in the middle of an outstanding access.
        @(negedge clk);
        extStall = 1'b0; flush = 1'b0; DmAck = 1'b0;
        driveEx(mk(K_SW, 32'h300, 32'h55AA55AA, 32'h0, 5'd3, 9, 0, 1'b0));
        #1;
        chk("rst_test_req", {31'd0, DmReq}, 32'd1);
        @(negedge clk);
        #1;
        chk("rst_test_wait_stall", {31'd0, MemStall_ME}, 32'd1);
        rst_n = 1'b0;
        driveEx(mk(K_BUB, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 1'b0));
        #1;
        chk("midwait_rst_req", {31'd0, DmReq}, 32'd0);
        chk("midwait_rst_stall", {31'd0, MemStall_ME}, 32'd0);
        chk("midwait_rst_me", ResultRdDat_ME | {25'd0, WriteReg_ME, RegWrite_ME, InstrVal_ME, AdrErr_ME}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("after_rst_idle", {30'd0, DmReq, MemStall_ME}, 32'd0);

        while (expQ.size() > 0 && killed[expQ[0].id]) void'(expQ.pop_front());
        chk("writebacks_left", 32'(expQ.size()), 32'd0);
        chk("mem_txns_left", 32'(memQ.size()), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
